// File: rtl/conv_input_sequencer_pkg.sv
// conv_seq_pkg: shared types and constants for the convolution input sequencer.
// Holds the sequencer state enum, vector geometry and the geometry port width.
package conv_seq_pkg;

    localparam int VEC_W      = 64;
    localparam int CH_PER_VEC = 8;
    localparam int PIPE_LAT   = 2;
    localparam int DIM_W      = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Number of 8-channel vectors per pixel; leftover channels are dropped.
    function automatic logic [DIM_W-1:0] groups_of(input logic [DIM_W-1:0] channels);
        return channels >> $clog2(CH_PER_VEC);
    endfunction

endpackage

// File: rtl/conv_input_sequencer_if.sv
// conv_input_sequencer_if: feature-map BRAM read port plus the pixel stream
// towards the window generator, including the downstream stall request.
// master = sequencer side, slave = BRAM / window generator side.
interface conv_input_sequencer_if #(
    parameter int ADDR_W = 20
);
    import conv_seq_pkg::*;

    logic              stall;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [VEC_W-1:0]  rd_data;
    logic [VEC_W-1:0]  pixel_out;
    logic              pixel_valid;
    logic              pixel_last;

    modport master (
        input  stall, rd_data,
        output rd_en, rd_addr, pixel_out, pixel_valid, pixel_last
    );

    modport slave (
        output stall, rd_data,
        input  rd_en, rd_addr, pixel_out, pixel_valid, pixel_last
    );

endinterface

// File: rtl/conv_input_sequencer_pos_counter.sv
// conv_seq_pos_counter: walks the zero-padded grid with g innermost, then x,
// then y, and flags border (pad) positions and the final position.
// x and y carry one extra bit so W+1 / H+1 never overflow.
module conv_seq_pos_counter
    import conv_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    input  logic [DIM_W-1:0] width,
    input  logic [DIM_W-1:0] height,
    input  logic [DIM_W-1:0] groups,
    output logic             is_pad,
    output logic             is_last
);

    logic [DIM_W-1:0] g;
    logic [DIM_W:0]   x;
    logic [DIM_W:0]   y;
    logic [DIM_W:0]   x_max;
    logic [DIM_W:0]   y_max;
    logic             g_wrap;
    logic             x_wrap;

    assign x_max  = {1'b0, width}  + (DIM_W+1)'(1);
    assign y_max  = {1'b0, height} + (DIM_W+1)'(1);
    assign g_wrap = (g == groups - DIM_W'(1));
    assign x_wrap = (x == x_max);

    assign is_pad  = (x == '0) || (x == x_max) || (y == '0) || (y == y_max);
    assign is_last = g_wrap && x_wrap && (y == y_max);

    // Nested counters: g rolls into x, x rolls into y; a new layer restarts at 0.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            g <= '0;
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (g_wrap) begin
                g <= '0;
                if (x_wrap) begin
                    x <= '0;
                    y <= y + (DIM_W+1)'(1);
                end else begin
                    x <= x + (DIM_W+1)'(1);
                end
            end else begin
                g <= g + DIM_W'(1);
            end
        end
    end

endmodule

// File: rtl/conv_input_sequencer.sv
// conv_input_sequencer: per-layer front end of the 3x3 window datapath.
// Issues one padded-grid position per unstalled RUN cycle, reads interior
// pixels from the feature-map BRAM and emits zero vectors on the border,
// two cycles after issue. Optional statistics counters are built only when
// CONV_SEQ_STATS_EN is defined; otherwise stat_* are tied to zero.
module conv_input_sequencer
    import conv_seq_pkg::*;
#(
    parameter int ADDR_W = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DIM_W-1:0]       cfg_width,
    input  logic [DIM_W-1:0]       cfg_height,
    input  logic [DIM_W-1:0]       cfg_channels,
    input  logic [ADDR_W-1:0]      cfg_base,
    conv_input_sequencer_if.master bus,
    output logic [DIM_W-1:0]       win_width,
    output logic [DIM_W-1:0]       win_channels,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            stat_beats,
    output logic [31:0]            stat_stalls
);

    state_t            state;
    state_t            state_next;
    logic [DIM_W-1:0]  width_q;
    logic [DIM_W-1:0]  height_q;
    logic [DIM_W-1:0]  groups_q;
    logic [DIM_W-1:0]  cfg_groups;
    logic [ADDR_W-1:0] addr_cnt;
    logic [1:0]        drain_cnt;
    logic              start_ok;
    logic              degenerate;
    logic              issue;
    logic              is_pad;
    logic              is_last;
    logic              s1_valid;
    logic              s1_pad;
    logic              s1_last;

    assign cfg_groups = groups_of(cfg_channels);
    assign start_ok   = start && (state == IDLE);
    assign degenerate = (cfg_groups == '0) || (cfg_width == '0) || (cfg_height == '0);
    assign issue      = (state == RUN) && !bus.stall;

    assign busy        = (state == RUN) || (state == DRAIN);
    assign done        = (state == DONE);
    assign bus.rd_en   = issue && !is_pad;
    assign bus.rd_addr = bus.rd_en ? addr_cnt : '0;

    conv_seq_pos_counter u_pos (
        .clk     (clk),
        .rst     (rst),
        .load    (start_ok),
        .advance (issue),
        .width   (width_q),
        .height  (height_q),
        .groups  (groups_q),
        .is_pad  (is_pad),
        .is_last (is_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state: degenerate layers skip straight to DONE; DRAIN waits out the pipeline.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = degenerate ? DONE : RUN;
            RUN:     if (issue && is_last) state_next = DRAIN;
            DRAIN:   if (drain_cnt == 2'(PIPE_LAT - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Cycles spent in DRAIN.
    always_ff @(posedge clk) begin
        if (rst || state != DRAIN) drain_cnt <= '0;
        else                       drain_cnt <= drain_cnt + 2'd1;
    end

    // Geometry latched on an accepted start; the window generator sees the padded width.
    always_ff @(posedge clk) begin
        if (rst) begin
            width_q      <= '0;
            height_q     <= '0;
            groups_q     <= '0;
            win_width    <= '0;
            win_channels <= '0;
        end else if (start_ok) begin
            width_q      <= cfg_width;
            height_q     <= cfg_height;
            groups_q     <= cfg_groups;
            win_width    <= cfg_width + DIM_W'(2);
            win_channels <= cfg_channels;
        end
    end

    // Interior reads are contiguous, so a plain incrementing address suffices.
    always_ff @(posedge clk) begin
        if (rst)            addr_cnt <= '0;
        else if (start_ok)  addr_cnt <= cfg_base;
        else if (bus.rd_en) addr_cnt <= addr_cnt + ADDR_W'(1);
    end

    // Stage 1: flags ride alongside the BRAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_pad   <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= issue;
            s1_pad   <= is_pad;
            s1_last  <= is_last;
        end
    end

    // Stage 2: register either a zero border vector or the BRAM word.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.pixel_valid <= 1'b0;
            bus.pixel_last  <= 1'b0;
            bus.pixel_out   <= '0;
        end else begin
            bus.pixel_valid <= s1_valid;
            bus.pixel_last  <= s1_valid && s1_last;
            bus.pixel_out   <= (s1_valid && !s1_pad) ? bus.rd_data : '0;
        end
    end

`ifdef CONV_SEQ_STATS_EN
    logic [31:0] beats_q;
    logic [31:0] stalls_q;

    // Saturating beat and stall counters, cleared per layer.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            beats_q  <= '0;
            stalls_q <= '0;
        end else begin
            if (bus.pixel_valid && beats_q != '1)
                beats_q <= beats_q + 32'd1;
            if (state == RUN && bus.stall && stalls_q != '1)
                stalls_q <= stalls_q + 32'd1;
        end
    end

    assign stat_beats  = beats_q;
    assign stat_stalls = stalls_q;
`else
    assign stat_beats  = '0;
    assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_conv_input_sequencer.sv
// tb_conv_input_sequencer: table-driven bench for conv_input_sequencer.
// Each table row is a layer; expected beats and read addresses are queued
// when the layer is started and popped as the DUT produces them.
// Stats checks follow CONV_SEQ_STATS_EN.
module tb_conv_input_sequencer;

    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   cfg_width;
    logic [15:0]   cfg_height;
    logic [15:0]   cfg_channels;
    logic [AW-1:0] cfg_base;
    logic [15:0]   win_width;
    logic [15:0]   win_channels;
    logic          busy;
    logic          done;
    logic [31:0]   stat_beats;
    logic [31:0]   stat_stalls;

    int checks   = 0;
    int failures = 0;

    logic [64:0]   exp_q[$];
    logic [AW-1:0] addr_q[$];

    typedef struct {
        int            w;
        int            h;
        int            c;
        logic [AW-1:0] base;
        int            stall_lo;
        int            stall_hi;
        int            extra_start;
        int            beats;
        int            first_cyc;
        int            last_cyc;
        int            done_cyc;
        int            reads;
        int            stall_beats;
        int            stalls;
    } vec_t;

    vec_t tbl[7];

    conv_input_sequencer_if #(.ADDR_W(AW)) bus();

    conv_input_sequencer #(.ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_width    (cfg_width),
        .cfg_height   (cfg_height),
        .cfg_channels (cfg_channels),
        .cfg_base     (cfg_base),
        .bus          (bus),
        .win_width    (win_width),
        .win_channels (win_channels),
        .busy         (busy),
        .done         (done),
        .stat_beats   (stat_beats),
        .stat_stalls  (stat_stalls)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_word(input logic [AW-1:0] a);
        return {~{12'h000, a}, 12'h5A0, a};
    endfunction

    // BRAM model with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem_word(bus.rd_addr);
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic build_expected(input vec_t v);
        logic [AW-1:0] a;
        int g;
        exp_q.delete();
        addr_q.delete();
        g = v.c >> 3;
        a = v.base;
        if (g == 0 || v.w == 0 || v.h == 0) return;
        for (int y = 0; y <= v.h + 1; y++)
            for (int x = 0; x <= v.w + 1; x++)
                for (int gi = 0; gi < g; gi++) begin
                    logic last;
                    last = (y == v.h + 1) && (x == v.w + 1) && (gi == g - 1);
                    if (x == 0 || x == v.w + 1 || y == 0 || y == v.h + 1) begin
                        exp_q.push_back({last, 64'h0});
                    end else begin
                        exp_q.push_back({last, mem_word(a)});
                        addr_q.push_back(a);
                        a = a + AW'(1);
                    end
                end
    endtask

    task automatic apply_stimulus(input vec_t v);
        int beats   = 0;
        int first   = -1;
        int last    = -1;
        int done_at = -1;
        int reads   = 0;
        int sbeats  = 0;
        int busy_bad = 0;
        logic [64:0] e;
        logic exp_busy;
        cfg_width    = 16'(v.w);
        cfg_height   = 16'(v.h);
        cfg_channels = 16'(v.c);
        cfg_base     = v.base;
        build_expected(v);
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #1;
            start     = (n == 0) || (n == v.extra_start);
            bus.stall = (n >= v.stall_lo) && (n <= v.stall_hi);
            #1;
            if (bus.rd_en) begin
                reads++;
                if (addr_q.size() == 0) check_output("rd_addr_extra", 64'(bus.rd_addr), 64'hFFFF_FFFF);
                else                    check_output("rd_addr", 64'(bus.rd_addr), 64'(addr_q.pop_front()));
            end
            if (bus.pixel_valid) begin
                beats++;
                if (first < 0) first = n;
                if (bus.stall) sbeats++;
                if (bus.pixel_last) last = n;
                if (exp_q.size() == 0) begin
                    check_output("extra_beat", 64'(beats), 64'(v.beats));
                end else begin
                    e = exp_q.pop_front();
                    check_output("pixel_out", bus.pixel_out, e[63:0]);
                    check_output("pixel_last", 64'(bus.pixel_last), 64'(e[64]));
                end
            end
            exp_busy = (v.beats > 0) && (n >= 1) && (n < v.done_cyc);
            if (busy !== exp_busy) busy_bad++;
            if (done) begin
                done_at = n;
                break;
            end
        end
        start     = 1'b0;
        bus.stall = 1'b0;
        check_output("done_cycle", 64'(done_at), 64'(v.done_cyc));
        check_output("beat_count", 64'(beats), 64'(v.beats));
        check_output("first_valid", 64'(first), 64'(v.first_cyc));
        check_output("last_cycle", 64'(last), 64'(v.last_cyc));
        check_output("read_count", 64'(reads), 64'(v.reads));
        check_output("busy_profile", 64'(busy_bad), 64'd0);
        check_output("left_in_queue", 64'(exp_q.size()), 64'd0);
        check_output("win_width", 64'(win_width), 64'(16'(v.w + 2)));
        check_output("win_channels", 64'(win_channels), 64'(16'(v.c)));
        if (v.stall_beats >= 0)
            check_output("beats_during_stall", 64'(sbeats), 64'(v.stall_beats));
`ifdef CONV_SEQ_STATS_EN
        check_output("stat_beats", 64'(stat_beats), 64'(v.beats));
        check_output("stat_stalls", 64'(stat_stalls), 64'(v.stalls));
`else
        check_output("stat_beats", 64'(stat_beats), 64'd0);
        check_output("stat_stalls", 64'(stat_stalls), 64'd0);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_rd_en"}, 64'(bus.rd_en), 64'd0);
        check_output({tag, "_rd_addr"}, 64'(bus.rd_addr), 64'd0);
        check_output({tag, "_pixel_valid"}, 64'(bus.pixel_valid), 64'd0);
        check_output({tag, "_pixel_last"}, 64'(bus.pixel_last), 64'd0);
        check_output({tag, "_pixel_out"}, bus.pixel_out, 64'd0);
        check_output({tag, "_busy"}, 64'(busy), 64'd0);
        check_output({tag, "_done"}, 64'(done), 64'd0);
        check_output({tag, "_win_width"}, 64'(win_width), 64'd0);
        check_output({tag, "_win_channels"}, 64'(win_channels), 64'd0);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        bus.stall    = 1'b0;
        bus.rd_data  = '0;
        cfg_width    = '0;
        cfg_height   = '0;
        cfg_channels = '0;
        cfg_base     = '0;

        //          w  h  c   base       slo   shi ext beats first last done reads sb  stalls
        tbl[0] = '{2, 2, 8,  20'h00100, 1000, 0,  0,  16,   3,   18,  19,  4,   -1, 0};
        tbl[1] = '{3, 1, 16, 20'h00200, 1000, 0,  0,  30,   3,   32,  33,  6,   -1, 0};
        tbl[2] = '{2, 2, 8,  20'h00100, 5,    8,  0,  16,   3,   22,  23,  4,   2,  4};
        tbl[3] = '{2, 2, 4,  20'h00100, 1000, 0,  0,  0,    -1,  -1,  1,   0,   -1, 0};
        tbl[4] = '{2, 1, 8,  20'hFFFFF, 1000, 0,  0,  12,   3,   14,  15,  2,   -1, 0};
        tbl[5] = '{2, 2, 8,  20'h00100, 1000, 0,  6,  16,   3,   18,  19,  4,   -1, 0};
        tbl[6] = '{0, 3, 8,  20'h00300, 1000, 0,  0,  0,    -1,  -1,  1,   0,   -1, 0};

        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        check_output("reset_stat_beats", 64'(stat_beats), 64'd0);
        check_output("reset_stat_stalls", 64'(stat_stalls), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            $display("[TB] layer %0d: W=%0d H=%0d C=%0d", i, tbl[i].w, tbl[i].h, tbl[i].c);
            apply_stimulus(tbl[i]);
        end

        // Reset in the middle of a layer, then a clean rerun from position 0.
        cfg_width    = 16'd2;
        cfg_height   = 16'd2;
        cfg_channels = 16'd8;
        cfg_base     = 20'h00100;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            start = (n == 0);
            rst   = (n == 7);
            #1;
            if (n == 6) check_output("midrun_busy", 64'(busy), 64'd1);
            if (n == 8) check_all_zero("after_rst_c8");
            if (n == 9) check_all_zero("after_rst_c9");
        end
        rst = 1'b0;
        apply_stimulus(tbl[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_input_sequencer.md
# conv_input_sequencer

Front-end controller for the 3x3 sliding-window datapath. Per layer it latches geometry, walks every position of the zero-padded input feature map in row-major / channel-group order, fetches real pixels from the input feature-map BRAM, and substitutes zero vectors at border positions. It streams 64-bit vectors, each carrying 8 channels × 8 bits, with a valid strobe into the window generator. It also drives that generator's width/channel configuration, so both blocks always use the same padded geometry.

## Interface
- ADDR_W, 20: feature-map BRAM word-address width.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle layer start; ignored unless IDLE.
- cfg_width  in  16  unpadded image width W.
- cfg_height  in  16  unpadded image height H.
- cfg_channels  in  16  input channels C; only C>>3 is used.
- cfg_base  in  ADDR_W  word address of pixel (0,0), group 0.
- stall  in  1  downstream pause request.
- rd_en  out  1  BRAM read enable.
- rd_addr  out  ADDR_W  BRAM read address.
- rd_data  in  64  BRAM data; valid exactly 1 cycle after rd_en.
- pixel_out  out  64  vector to window generator.
- pixel_valid  out  1  vector qualifier; drives window data_valid.
- pixel_last  out  1  high with the final beat of the layer.
- win_width  out  16  latched W+2, for window img_width.
- win_channels  out  16  latched C, for window in_channels.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- stat_beats, stat_stalls  out  32 each  see Configuration.

## Operation
- Counter groups: G = C>>3. Padded grid is (W+2) × (H+2). Total beats = G·(W+2)·(H+2).
- States:
  - IDLE → RUN on start (rst low, G, W and H all nonzero). Latch cfg_*, zero g/x/y, set addr counter = cfg_base.
  - IDLE → DONE on start if G, W or H is zero. No beats are emitted.
  - RUN → DRAIN after the last position issues.
  - DRAIN: lasts 2 cycles while the pipeline empties, then → DONE.
  - DONE: lasts 1 cycle, done=1, then → IDLE.
- Position order: innermost g ∈ [0,G), then x ∈ [0,W+1], then y ∈ [0,H+1].
- One position issues per RUN cycle with stall low. No position issues when stall is high.
- Pad position (x==0 | x==W+1 | y==0 | y==H+1): rd_en=0, emitted vector is 64'h0.
- Interior position: rd_en=1, rd_addr = addr counter, then addr counter += 1.
  - Addresses are therefore contiguous: cfg_base + ((y-1)·W + (x-1))·G + g, with no multiplier.
  - Address wraps modulo 2^ADDR_W.
- Pipeline: the pad flag and last flag travel alongside each issued position. Output stage registers either zero or rd_data.
- win_width / win_channels: update on an accepted start and hold until the next one.
- start while busy: ignored. rst wins over a simultaneous start.
- rst mid-layer: next cycle IDLE, in-flight beats discarded, all outputs at reset values.

## Timing
- Reset values: all outputs 0; win_width=0, win_channels=0.
- start sampled in cycle 0. RUN and busy=1 from cycle 1. First position issues in cycle 1.
- Position issued in cycle t: pixel_valid/pixel_out in cycle t+2, for both pad and interior positions.
- Stall sampled in cycle t blocks issue in t. Positions issued at t-1 and t-2 still emerge.
  - Downstream must absorb up to 2 valid beats after raising stall.
  - Releasing stall resumes issue in the same cycle.
- Last position issued in cycle L:
  - pixel_valid & pixel_last in L+2.
  - done=1 and busy=0 in L+3.
- Degenerate config: done in cycle 1, no pixel_valid.

## Configuration
- CONV_SEQ_STATS_EN defined:
  - stat_beats counts pixel_valid cycles.
  - stat_stalls counts RUN cycles with stall high.
  - Both clear on accepted start and on rst, saturate at 2^32-1, and hold after done.
- Undefined: both outputs tied to 0, no counter logic.

## Structure
- Package conv_seq_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - VEC_W=64, CH_PER_VEC=8, PIPE_LAT=2;
  - DIM_W=16 for geometry ports.
- One sub-module: conv_seq_pos_counter.
  - Nested g/x/y counters with an advance enable.
  - Outputs is_pad and is_last for the current position.

## Test plan
- W=2,H=2,C=8,base=0x100, no stall:
  - 16 beats; pixel_valid cycles 3–18.
  - Nonzero beats at indices 5,6,9,10 = mem[0x100..0x103].
  - pixel_last in cycle 18, done in cycle 19.
- W=3,H=1,C=16:
  - 30 beats, 6 reads at consecutive addresses.
  - Zero vectors at all x=0/x=4/y=0/y=2 positions.
- Same as case 1 with stall high in cycles 5–8:
  - Exactly 2 valid beats during the stall.
  - Stream order and data unchanged; done delayed by 4 cycles.
- C=4 (G=0): done in cycle 1, no rd_en, no pixel_valid, busy never asserted.
- rst in cycle 7 of a run:
  - all outputs 0 from cycle 8;
  - a new start then runs from position 0 with the correct addresses.
- start pulsed while busy: ignored. With CONV_SEQ_STATS_EN, case 3 gives stat_beats=16, stat_stalls=4.
